fp_adder: RTL and testbench

- Multi-cycle IEEE-754 floating-point adder/subtractor for binary32 (single) and binary16 (half) operands.
- Uses a start/valid handshake and has one result register.
- Sits behind the FPU operand/opcode decoder and feeds the writeback stage, which provides back-pressure on ready_in.
- Supports round-to-nearest-even and round-toward-zero, and produces five IEEE exception flags.

---
 rtl/fp_adder.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_fp_adder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fp_adder.sv
// fp_adder: multi-cycle IEEE-754 binary32/binary16 add/subtract with RNE/RTZ rounding.
// Optional macro FP_ADDER_FTZ_EN flushes subnormal inputs and tiny results to signed zero.
module fp_adder (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [2:0]  op_code,
    input  logic        mode_fp,
    input  logic        round_mode,
    input  logic        start,
    input  logic        ready_in,
    output logic [31:0] result,
    output logic        valid_out,
    output logic [4:0]  flags
);

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
    } state_t;

    // Half fractions are left-aligned into the 24-bit mantissa so both formats share one datapath.
    typedef struct packed {
        logic        sign;
        logic [9:0]  exp;
        logic [23:0] man;
        logic        nan;
        logic        snan;
        logic        inf;
    } unp_t;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  flg;
    } rnd_t;

    function automatic unp_t unpack(input logic [31:0] x, input logic single);
        unp_t        u;
        logic [7:0]  e;
        logic [22:0] f;
        logic        all_ones;
        if (single) begin
            u.sign   = x[31];
            e        = x[30:23];
            f        = x[22:0];
            all_ones = (e == 8'hFF);
        end else begin
            u.sign   = x[15];
            e        = {3'b000, x[14:10]};
            f        = {x[9:0], 13'b0};
            all_ones = (e == 8'h1F);
        end
        u.nan  = all_ones && (f != 23'd0);
        u.snan = u.nan && !f[22];
        u.inf  = all_ones && (f == 23'd0);
`ifdef FP_ADDER_FTZ_EN
        if (e == 8'd0) f = 23'd0;
`endif
        u.man = {(e != 8'd0), f};
        u.exp = (e == 8'd0) ? 10'd1 : {2'b00, e};
        return u;
    endfunction

    function automatic logic [31:0] inf_of(input logic sign, input logic single);
        return single ? {sign, 8'hFF, 23'h0} : {16'h0000, sign, 5'h1F, 10'h000};
    endfunction

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd27;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (v[i] && !found) begin
                n     = 5'(26 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // m carries the hidden bit at [26]; the round point depends on the format.
    function automatic rnd_t round_pack(input logic [26:0] m, input logic [9:0] exp,
                                        input logic sign, input logic single, input logic rtz);
        rnd_t        r;
        logic [23:0] kept;
        logic [23:0] man;
        logic [24:0] sum;
        logic [9:0]  e;
        logic [9:0]  emax;
        logic        g, rb, s, lsb, inc, nx, tiny, ovf;
        kept = single ? m[26:3] : {m[26:16], 13'b0};
        g    = single ? m[2] : m[15];
        rb   = single ? m[1] : m[14];
        s    = single ? m[0] : |m[13:0];
        lsb  = single ? m[3] : m[16];
        nx   = g | rb | s;
        inc  = !rtz && g && (rb || s || lsb);
        sum  = {1'b0, kept} + (inc ? (single ? 25'h1 : 25'h2000) : 25'h0);
        if (sum[24]) begin
            man = sum[24:1];
            e   = exp + 10'd1;
        end else begin
            man = sum[23:0];
            e   = exp;
        end
        emax  = single ? 10'd255 : 10'd31;
        tiny  = !man[23];
        ovf   = !tiny && (e >= emax);
        r.flg = {3'b000, tiny && nx, nx};
        if (tiny) e = 10'd0;
        if (single) r.res = {sign, e[7:0], man[22:0]};
        else        r.res = {16'h0000, sign, e[4:0], man[22:13]};
`ifdef FP_ADDER_FTZ_EN
        if (tiny) begin
            r.res = single ? {sign, 31'h0} : {16'h0000, sign, 15'h0};
            r.flg = 5'b00011;
        end
`endif
        if (ovf) begin
            if (rtz) r.res = single ? {sign, 8'hFE, 23'h7FFFFF} : {16'h0000, sign, 5'h1E, 10'h3FF};
            else     r.res = inf_of(sign, single);
            r.flg = 5'b00101;
        end
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic        sub_q, sub_d, single_q, single_d, rtz_q, rtz_d;
    logic        sign_big_q, sign_big_d, eff_sub_q, eff_sub_d, zero_sign_q, zero_sign_d;
    logic        spec_q, spec_d;
    logic [31:0] spec_res_q, spec_res_d;
    logic [4:0]  spec_flg_q, spec_flg_d;
    logic [9:0]  exp_big_q, exp_big_d, shift_q, shift_d;
    logic [23:0] man_big_q, man_big_d, man_small_q, man_small_d;
    logic [26:0] big_al_q, big_al_d, small_al_q, small_al_d;
    logic [27:0] sum_q, sum_d;
    logic [26:0] norm_man_q, norm_man_d;
    logic [9:0]  norm_exp_q, norm_exp_d;
    logic        zero_q, zero_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  flags_q, flags_d;

    unp_t        ua, ub;
    rnd_t        rnd;
    logic        a_ge_b;
    logic [31:0] qnan;
    logic [53:0] full;
    logic [4:0]  lz;
    logic [9:0]  sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= 32'h0;
            flags_q  <= 5'h0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q         <= a_d;
        b_q         <= b_d;
        sub_q       <= sub_d;
        single_q    <= single_d;
        rtz_q       <= rtz_d;
        sign_big_q  <= sign_big_d;
        eff_sub_q   <= eff_sub_d;
        zero_sign_q <= zero_sign_d;
        spec_q      <= spec_d;
        spec_res_q  <= spec_res_d;
        spec_flg_q  <= spec_flg_d;
        exp_big_q   <= exp_big_d;
        shift_q     <= shift_d;
        man_big_q   <= man_big_d;
        man_small_q <= man_small_d;
        big_al_q    <= big_al_d;
        small_al_q  <= small_al_d;
        sum_q       <= sum_d;
        norm_man_q  <= norm_man_d;
        norm_exp_q  <= norm_exp_d;
        zero_q      <= zero_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_UNPACK;
            S_UNPACK: state_d = S_ALIGN;
            S_ALIGN:  state_d = S_ADD;
            S_ADD:    state_d = S_NORM;
            S_NORM:   state_d = S_ROUND;
            S_ROUND:  state_d = S_DONE;
            S_DONE:   if (ready_in) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        valid_out = (state_q == S_DONE);
        result    = result_q;
        flags     = flags_q;
    end

    always_comb begin
        ua     = unpack(a_q, single_q);
        ub     = unpack(b_q, single_q);
        ub.sign = ub.sign ^ sub_q;
        a_ge_b = {ua.exp, ua.man} >= {ub.exp, ub.man};
        qnan   = single_q ? 32'h7FC00000 : 32'h00007E00;
        full   = {man_small_q, 3'b000, 27'd0} >> shift_q;
        lz     = lzc27(sum_q[26:0]);
        sh     = ({5'd0, lz} < (exp_big_q - 10'd1)) ? {5'd0, lz} : (exp_big_q - 10'd1);
        rnd    = round_pack(norm_man_q, norm_exp_q, sign_big_q, single_q, rtz_q);

        a_d = a_q; b_d = b_q; sub_d = sub_q; single_d = single_q; rtz_d = rtz_q;
        sign_big_d = sign_big_q; eff_sub_d = eff_sub_q; zero_sign_d = zero_sign_q;
        spec_d = spec_q; spec_res_d = spec_res_q; spec_flg_d = spec_flg_q;
        exp_big_d = exp_big_q; shift_d = shift_q;
        man_big_d = man_big_q; man_small_d = man_small_q;
        big_al_d = big_al_q; small_al_d = small_al_q; sum_d = sum_q;
        norm_man_d = norm_man_q; norm_exp_d = norm_exp_q; zero_d = zero_q;
        result_d = result_q; flags_d = flags_q;

        case (state_q)
            S_IDLE: if (start) begin
                a_d      = op_a;
                b_d      = op_b;
                sub_d    = (op_code == 3'b001);
                single_d = mode_fp;
                rtz_d    = round_mode;
            end
            // UNPACK: classify, order by magnitude, resolve specials
            S_UNPACK: begin
                sign_big_d  = a_ge_b ? ua.sign : ub.sign;
                exp_big_d   = a_ge_b ? ua.exp : ub.exp;
                shift_d     = a_ge_b ? (ua.exp - ub.exp) : (ub.exp - ua.exp);
                man_big_d   = a_ge_b ? ua.man : ub.man;
                man_small_d = a_ge_b ? ub.man : ua.man;
                eff_sub_d   = ua.sign ^ ub.sign;
                zero_sign_d = ua.sign & ub.sign;
                spec_d      = ua.nan | ub.nan | ua.inf | ub.inf;
                spec_res_d  = 32'h0;
                spec_flg_d  = 5'h0;
                if (ua.nan || ub.nan) begin
                    spec_res_d = qnan;
                    spec_flg_d = {ua.snan | ub.snan, 4'b0000};
                end else if (ua.inf && ub.inf && (ua.sign != ub.sign)) begin
                    spec_res_d = qnan;
                    spec_flg_d = 5'b10000;
                end else if (ua.inf) begin
                    spec_res_d = inf_of(ua.sign, single_q);
                end else if (ub.inf) begin
                    spec_res_d = inf_of(ub.sign, single_q);
                end
            end
            // ALIGN: shift the smaller operand, jamming lost bits into sticky
            S_ALIGN: begin
                big_al_d = {man_big_q, 3'b000};
                if (shift_q >= 10'd27) small_al_d = {26'd0, |man_small_q};
                else                   small_al_d = full[53:27] | {26'd0, |full[26:0]};
            end
            // ADD
            S_ADD: begin
                sum_d = eff_sub_q ? ({1'b0, big_al_q} - {1'b0, small_al_q})
                                  : ({1'b0, big_al_q} + {1'b0, small_al_q});
            end
            // NORM: left shift stops at exponent 1 so tiny results stay subnormal
            S_NORM: begin
                zero_d = (sum_q == 28'd0);
                if (sum_q[27]) begin
                    norm_man_d = sum_q[27:1] | {26'd0, sum_q[0]};
                    norm_exp_d = exp_big_q + 10'd1;
                end else begin
                    norm_man_d = sum_q[26:0] << sh;
                    norm_exp_d = exp_big_q - sh;
                end
            end
            // ROUND
            S_ROUND: begin
                if (spec_q) begin
                    result_d = spec_res_q;
                    flags_d  = spec_flg_q;
                end else if (zero_q) begin
                    result_d = single_q ? {zero_sign_q, 31'h0} : {16'h0000, zero_sign_q, 15'h0};
                    flags_d  = 5'h0;
                end else begin
                    result_d = rnd.res;
                    flags_d  = rnd.flg;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fp_adder.sv
// Directed-vector bench for fp_adder: table of hand-computed sums plus handshake/reset sequences.
module tb_fp_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] op_a, op_b;
    logic [2:0]  op_code;
    logic        mode_fp, round_mode, start, ready_in;
    logic [31:0] result;
    logic        valid_out;
    logic [4:0]  flags;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        mode;
        logic        rm;
        logic [31:0] res;
        logic [4:0]  flg;
    } vec_t;

    vec_t vecs[$];

    fp_adder dut (
        .clk(clk), .rst(rst), .op_a(op_a), .op_b(op_b), .op_code(op_code),
        .mode_fp(mode_fp), .round_mode(round_mode), .start(start), .ready_in(ready_in),
        .result(result), .valid_out(valid_out), .flags(flags)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic add_vec(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                           input logic mode, input logic rm, input logic [31:0] res, input logic [4:0] flg);
        vec_t v;
        v.a = a; v.b = b; v.op = op; v.mode = mode; v.rm = rm; v.res = res; v.flg = flg;
        vecs.push_back(v);
    endtask

    // Issue one operation, scramble inputs after the start edge, and wait (bounded) for valid_out.
    task automatic launch(input vec_t v, output int lat);
        op_a = v.a; op_b = v.b; op_code = v.op; mode_fp = v.mode; round_mode = v.rm;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op_a = 32'h3F800000; op_b = 32'h3F800000; op_code = 3'b001;
        mode_fp = ~v.mode; round_mode = ~v.rm;
        lat = 0;
        while (!valid_out && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int          lat;
        logic        seen;
        logic [31:0] held;

        rst = 1'b1; op_a = '0; op_b = '0; op_code = '0; mode_fp = 1'b1;
        round_mode = 1'b0; start = 1'b0; ready_in = 1'b0;

        add_vec(32'h41A60000, 32'h40100000, 3'b000, 1'b1, 1'b0, 32'h41B80000, 5'b00000);
        add_vec(32'h40A80000, 32'h41940000, 3'b000, 1'b1, 1'b0, 32'h41BE0000, 5'b00000);
        add_vec(32'h41020000, 32'hC1040000, 3'b000, 1'b1, 1'b0, 32'hBE000000, 5'b00000);
        add_vec(32'h41600000, 32'hC1440000, 3'b000, 1'b1, 1'b0, 32'h3FE00000, 5'b00000);
        add_vec(32'h3F800000, 32'h3F800000, 3'b001, 1'b1, 1'b0, 32'h00000000, 5'b00000);
        add_vec(32'h00000000, 32'h00000000, 3'b000, 1'b1, 1'b0, 32'h00000000, 5'b00000);
        add_vec(32'h00000000, 32'h80000000, 3'b000, 1'b1, 1'b0, 32'h00000000, 5'b00000);
        add_vec(32'h80000000, 32'h80000000, 3'b000, 1'b1, 1'b0, 32'h80000000, 5'b00000);
        add_vec(32'h00000002, 32'h00000002, 3'b000, 1'b1, 1'b0, 32'h00000004, 5'b00000);
        add_vec(32'h7F800000, 32'h7F800000, 3'b000, 1'b1, 1'b0, 32'h7F800000, 5'b00000);
        add_vec(32'h7F800000, 32'hFF800000, 3'b000, 1'b1, 1'b0, 32'h7FC00000, 5'b10000);
        add_vec(32'h7F7FFFFF, 32'h7F7FFFFF, 3'b000, 1'b1, 1'b0, 32'h7F800000, 5'b00101);
        add_vec(32'h7F7FFFFF, 32'h7F7FFFFF, 3'b000, 1'b1, 1'b1, 32'h7F7FFFFF, 5'b00101);
        add_vec(32'h00004680, 32'h00004EB0, 3'b000, 1'b0, 1'b0, 32'h00005028, 5'b00000);
        add_vec(32'h00003B00, 32'h00005702, 3'b000, 1'b0, 1'b0, 32'h00005710, 5'b00000);
        add_vec(32'h00000000, 32'h00000000, 3'b000, 1'b0, 1'b0, 32'h00000000, 5'b00000);
        add_vec(32'hABCD4680, 32'h12344EB0, 3'b000, 1'b0, 1'b0, 32'h00005028, 5'b00000);
        add_vec(32'h3F800000, 32'h33800000, 3'b000, 1'b1, 1'b0, 32'h3F800000, 5'b00001);
        add_vec(32'h3F800001, 32'h33800000, 3'b000, 1'b1, 1'b0, 32'h3F800002, 5'b00001);
        add_vec(32'h3F800001, 32'h33800000, 3'b000, 1'b1, 1'b1, 32'h3F800001, 5'b00001);
        add_vec(32'h7F800001, 32'h3F800000, 3'b000, 1'b1, 1'b0, 32'h7FC00000, 5'b10000);
        add_vec(32'h7FC00000, 32'h3F800000, 3'b000, 1'b1, 1'b0, 32'h7FC00000, 5'b00000);
        add_vec(32'h3F800000, 32'h3F800000, 3'b010, 1'b1, 1'b0, 32'h40000000, 5'b00000);
        add_vec(32'h40000000, 32'hC0000000, 3'b001, 1'b1, 1'b0, 32'h40800000, 5'b00000);
        add_vec(32'hFF800000, 32'h3F800000, 3'b000, 1'b1, 1'b0, 32'hFF800000, 5'b00000);
        add_vec(32'h00003C00, 32'h00003C00, 3'b001, 1'b0, 1'b0, 32'h00000000, 5'b00000);
        add_vec(32'h00007BFF, 32'h00007BFF, 3'b000, 1'b0, 1'b0, 32'h00007C00, 5'b00101);
        add_vec(32'h00007BFF, 32'h00007BFF, 3'b000, 1'b0, 1'b1, 32'h00007BFF, 5'b00101);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_valid", 0, {31'd0, valid_out}, 32'd0);
        check("reset_result", 0, result, 32'd0);
        check("reset_flags", 0, {27'd0, flags}, 32'd0);

        foreach (vecs[i]) begin
            launch(vecs[i], lat);
            check("latency", i, 32'(lat), 32'd5);
            check("result", i, result, vecs[i].res);
            check("flags", i, {27'd0, flags}, {27'd0, vecs[i].flg});
            ready_in = 1'b1;
            @(posedge clk); #1;
            ready_in = 1'b0;
            check("valid_drop", i, {31'd0, valid_out}, 32'd0);
        end

        // Back-pressure: hold DONE for three cycles with a stray start pulse in the middle.
        launch(vecs[0], lat);
        check("bp_latency", 0, 32'(lat), 32'd5);
        held = result;
        for (int k = 0; k < 3; k++) begin
            op_a = 32'h40000000; op_b = 32'h40000000; op_code = 3'b000; mode_fp = 1'b1;
            start = (k == 1);
            @(posedge clk); #1;
            start = 1'b0;
            check("bp_valid", k, {31'd0, valid_out}, 32'd1);
            check("bp_result", k, result, 32'h41B80000);
            check("bp_flags", k, {27'd0, flags}, 32'd0);
        end
        ready_in = 1'b1;
        @(posedge clk); #1;
        ready_in = 1'b0;
        check("bp_release", 0, {31'd0, valid_out}, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (valid_out) seen = 1'b1;
        end
        check("bp_no_queue", 0, {31'd0, seen}, 32'd0);
        check("bp_result_kept", 0, result, held);

        // Reset while the operation sits in ALIGN: it must be discarded.
        op_a = 32'h40A80000; op_b = 32'h41940000; op_code = 3'b000; mode_fp = 1'b1; round_mode = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_result", 0, result, 32'd0);
        check("rst_flags", 0, {27'd0, flags}, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (valid_out) seen = 1'b1;
        end
        check("rst_no_valid", 0, {31'd0, seen}, 32'd0);
        check("rst_result_after", 0, result, 32'd0);

        // Recovery after the mid-operation reset.
        launch(vecs[1], lat);
        check("recover_latency", 0, 32'(lat), 32'd5);
        check("recover_result", 0, result, 32'h41BE0000);
        ready_in = 1'b1;
        @(posedge clk); #1;
        ready_in = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
